// File: rtl/br_lite_pkg.sv
// BrLitePkg: service classes carried by injected packets.
// No ports; shared type package.
package BrLitePkg;

    typedef enum logic [1:0] {
        BR_SVC_UNI  = 2'd0,
        BR_SVC_ALL  = 2'd1,
        BR_SVC_MON  = 2'd2,
        BR_SVC_SYNC = 2'd3
    } br_svc_t;

endpackage

// File: rtl/br_scenario_injector_pkg.sv
// Scenario package: record layout, default scenario constants and a
// saturating counter helper shared by the injector and its channels.
// No ports.
package br_scenario_injector_pkg;

    import BrLitePkg::*;

    localparam int REC_TS_W       = 32;
    localparam int DEF_PE_CNT     = 64;
    localparam int DEF_NPKTS      = 29;
    localparam int DEF_TS_W       = 32;
    localparam int DEF_PERIOD     = 2000;

    typedef struct packed {
        logic [REC_TS_W-1:0] timestamp;
        int                  source;
        int                  target;
        logic [31:0]         payload;
        br_svc_t             service;
    } record_t;

    // Timestamp no counter of REC_TS_W bits or narrower ever passes before
    // saturating; used to park unused table slots.
    localparam logic [REC_TS_W-1:0] TS_NEVER = '1;

    localparam record_t REC_IDLE = '{
        timestamp: TS_NEVER,
        source:    0,
        target:    0,
        payload:   32'h0,
        service:   BR_SVC_UNI
    };

    function automatic logic [15:0] sat16_add(input logic [15:0] a, input logic [16:0] b);
        logic [17:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s > 18'h0FFFF) ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/br_inj_channel.sv
// br_inj_channel: one injection channel. Picks the lowest-index ready record
// whose source matches this channel, presents it until acknowledged, and
// reports the accepted record as a one-hot issue mask.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   ack_i          consumer accepts the presented record
//   ready_i        per-record ready mask (unissued, due, valid source, enabled)
//   records_i      scenario table
//   req_o          record presented
//   tgt_o/payload_o/svc_o  presented record fields
//   accept_o       handshake completes this cycle
//   clr_o          one-hot index of the record accepted this cycle
module br_inj_channel
    import BrLitePkg::*, br_scenario_injector_pkg::*;
#(
    parameter int NPKTS = DEF_NPKTS,
    parameter int CH    = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ack_i,
    input  logic [NPKTS-1:0] ready_i,
    input  record_t          records_i [NPKTS],
    output logic             req_o,
    output int               tgt_o,
    output logic [31:0]      payload_o,
    output br_svc_t          svc_o,
    output logic             accept_o,
    output logic [NPKTS-1:0] clr_o
);

    localparam int IDX_W = (NPKTS > 1) ? $clog2(NPKTS) : 1;

    logic             r_req;
    logic [IDX_W-1:0] r_idx;
    int               r_tgt;
    logic [31:0]      r_payload;
    br_svc_t          r_svc;

    logic             w_idle;
    logic             w_found;
    logic [IDX_W-1:0] w_sel;
    record_t          w_rec;

    always_comb begin
        accept_o = r_req & ack_i;
        w_idle   = ~r_req | accept_o;
        w_found  = 1'b0;
        w_sel    = '0;
        w_rec    = '0;
        // Descending scan so the lowest matching index wins. The record being
        // accepted right now is still unissued, so it is masked out to let the
        // next one follow back-to-back.
        for (int i = NPKTS - 1; i >= 0; i--) begin
            if (ready_i[i] && (records_i[i].source == CH) &&
                !(accept_o && (r_idx == IDX_W'(i)))) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(i);
                w_rec   = records_i[i];
            end
        end
        clr_o = accept_o ? (NPKTS'(1) << r_idx) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req     <= 1'b0;
            r_idx     <= '0;
            r_tgt     <= 0;
            r_payload <= '0;
            r_svc     <= BR_SVC_UNI;
        end else if (w_idle) begin
            r_req <= w_found;
            if (w_found) begin
                r_idx     <= w_sel;
                r_tgt     <= w_rec.target;
                r_payload <= w_rec.payload;
                r_svc     <= w_rec.service;
            end
        end
    end

    assign req_o     = r_req;
    assign tgt_o     = r_tgt;
    assign payload_o = r_payload;
    assign svc_o     = r_svc;

endmodule

// File: rtl/br_scenario_injector.sv
// br_scenario_injector: replays a static table of timestamped records onto
// per-PE request/acknowledge channels, driven by a free-running cycle counter.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_i                advance counter and issue new records
//   records_i           scenario table (static while enabled)
//   req_o, ack_i        per-channel handshake
//   tgt_o/payload_o/svc_o  per-channel presented fields
//   cycle_o             current counter value (saturating)
//   sent_cnt_o          records accepted (saturating)
//   drop_cnt_o          records with out-of-range source (saturating)
//   epoch_o             completed replays
//   done_o              all records issued or dropped, no request pending
module br_scenario_injector
    import BrLitePkg::*, br_scenario_injector_pkg::*;
#(
    parameter int PE_CNT = DEF_PE_CNT,
    parameter int NPKTS  = DEF_NPKTS,
    parameter int TS_W   = DEF_TS_W,
    parameter int REPEAT = 0,
    parameter int PERIOD = DEF_PERIOD
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  record_t           records_i [NPKTS],
    output logic [PE_CNT-1:0] req_o,
    input  logic [PE_CNT-1:0] ack_i,
    output int                tgt_o     [PE_CNT],
    output logic [31:0]       payload_o [PE_CNT],
    output br_svc_t           svc_o     [PE_CNT],
    output logic [TS_W-1:0]   cycle_o,
    output logic [15:0]       sent_cnt_o,
    output logic [15:0]       drop_cnt_o,
    output logic [7:0]        epoch_o,
    output logic              done_o
);

    localparam int              CMP_W    = (TS_W > REC_TS_W) ? TS_W : REC_TS_W;
    localparam logic [TS_W-1:0] CYC_LAST = TS_W'(PERIOD - 1);

    logic [TS_W-1:0]  r_cycle;
    logic [NPKTS-1:0] r_issued;
    logic [15:0]      r_sent;
    logic [15:0]      r_drop;
    logic [7:0]       r_epoch;

    logic [NPKTS-1:0]  w_ready;
    logic [NPKTS-1:0]  w_drop;
    logic [NPKTS-1:0]  w_issue_set;
    logic [PE_CNT-1:0] w_accept;
    logic [NPKTS-1:0]  w_clr [PE_CNT];
    logic [16:0]       w_n_sent;
    logic [16:0]       w_n_drop;
    logic              w_due;
    logic              w_src_ok;
    logic              w_done;
    logic              w_restart;

    always_comb begin
        w_ready  = '0;
        w_drop   = '0;
        w_n_drop = '0;
        w_due    = 1'b0;
        w_src_ok = 1'b0;
        for (int i = 0; i < NPKTS; i++) begin
            w_due    = ~r_issued[i] &&
                       (CMP_W'(records_i[i].timestamp) <= CMP_W'(r_cycle));
            w_src_ok = (records_i[i].source >= 0) && (records_i[i].source < PE_CNT);
            w_ready[i] = w_due & w_src_ok & en_i;
            w_drop[i]  = w_due & ~w_src_ok;
            w_n_drop   = w_n_drop + 17'(w_drop[i]);
        end
    end

    always_comb begin
        w_issue_set = w_drop;
        w_n_sent    = '0;
        for (int p = 0; p < PE_CNT; p++) begin
            w_issue_set = w_issue_set | w_clr[p];
            w_n_sent    = w_n_sent + 17'(w_accept[p]);
        end
    end

    assign w_done    = (&r_issued) & ~(|req_o);
    assign w_restart = (REPEAT != 0) && w_done && (r_cycle >= CYC_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle  <= '0;
            r_issued <= '0;
            r_sent   <= '0;
            r_drop   <= '0;
            r_epoch  <= '0;
        end else if (w_restart) begin
            r_cycle  <= '0;
            r_issued <= '0;
            r_epoch  <= r_epoch + 8'd1;
        end else begin
            if (en_i && (r_cycle != '1)) begin
                r_cycle <= r_cycle + 1'b1;
            end
            r_issued <= r_issued | w_issue_set;
            r_sent   <= sat16_add(r_sent, w_n_sent);
            r_drop   <= sat16_add(r_drop, w_n_drop);
        end
    end

    for (genvar p = 0; p < PE_CNT; p++) begin : g_ch
        br_inj_channel #(
            .NPKTS (NPKTS),
            .CH    (p)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .ack_i     (ack_i[p]),
            .ready_i   (w_ready),
            .records_i (records_i),
            .req_o     (req_o[p]),
            .tgt_o     (tgt_o[p]),
            .payload_o (payload_o[p]),
            .svc_o     (svc_o[p]),
            .accept_o  (w_accept[p]),
            .clr_o     (w_clr[p])
        );
    end

    assign cycle_o    = r_cycle;
    assign sent_cnt_o = r_sent;
    assign drop_cnt_o = r_drop;
    assign epoch_o    = r_epoch;
    assign done_o     = w_done;

endmodule

// File: tb/tb_br_scenario_injector.sv
module tb_br_scenario_injector;

    import BrLitePkg::*;
    import br_scenario_injector_pkg::*;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default PE_CNT, small table
    logic        rst_a, en_a;
    record_t     rec_a [8];
    logic [63:0] req_a, ack_a;
    int          tgt_a [64];
    logic [31:0] pay_a [64];
    br_svc_t     svc_a [64];
    logic [31:0] cycle_a;
    logic [15:0] sent_a, drop_a;
    logic [7:0]  epoch_a;
    logic        done_a;

    // Instance B: PE_CNT=16, drop case
    logic        rst_b, en_b;
    record_t     rec_b [2];
    logic [15:0] req_b, ack_b;
    int          tgt_b [16];
    logic [31:0] pay_b [16];
    br_svc_t     svc_b [16];
    logic [31:0] cycle_b;
    logic [15:0] sent_b, drop_b;
    logic [7:0]  epoch_b;
    logic        done_b;

    // Instance C: periodic replay
    logic        rst_c, en_c;
    record_t     rec_c [1];
    logic [7:0]  req_c, ack_c;
    int          tgt_c [8];
    logic [31:0] pay_c [8];
    br_svc_t     svc_c [8];
    logic [31:0] cycle_c;
    logic [15:0] sent_c, drop_c;
    logic [7:0]  epoch_c;
    logic        done_c;

    br_scenario_injector #(.PE_CNT(64), .NPKTS(8)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .en_i(en_a), .records_i(rec_a),
        .req_o(req_a), .ack_i(ack_a), .tgt_o(tgt_a), .payload_o(pay_a), .svc_o(svc_a),
        .cycle_o(cycle_a), .sent_cnt_o(sent_a), .drop_cnt_o(drop_a),
        .epoch_o(epoch_a), .done_o(done_a)
    );

    br_scenario_injector #(.PE_CNT(16), .NPKTS(2)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .records_i(rec_b),
        .req_o(req_b), .ack_i(ack_b), .tgt_o(tgt_b), .payload_o(pay_b), .svc_o(svc_b),
        .cycle_o(cycle_b), .sent_cnt_o(sent_b), .drop_cnt_o(drop_b),
        .epoch_o(epoch_b), .done_o(done_b)
    );

    br_scenario_injector #(.PE_CNT(8), .NPKTS(1), .REPEAT(1), .PERIOD(100)) dut_c (
        .clk_i(clk), .rst_i(rst_c), .en_i(en_c), .records_i(rec_c),
        .req_o(req_c), .ack_i(ack_c), .tgt_o(tgt_c), .payload_o(pay_c), .svc_o(svc_c),
        .cycle_o(cycle_c), .sent_cnt_o(sent_c), .drop_cnt_o(drop_c),
        .epoch_o(epoch_c), .done_o(done_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance on falling edges until instance A's counter reads t.
    task automatic wait_cyc(input logic [31:0] t);
        int n;
        n = 0;
        while (cycle_a !== t && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_cycle_%0d", t), cycle_a, t);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a  = 1'b0; en_b  = 1'b0; en_c  = 1'b0;
        ack_a = '1; ack_a[0] = 1'b0;
        ack_b = '1;
        ack_c = '1;

        rec_a[0] = '{32'd4,    4, 0, 32'h01, BR_SVC_ALL};
        rec_a[1] = '{32'd420,  4, 5, 32'hA4, BR_SVC_UNI};
        rec_a[2] = '{32'd410,  7, 5, 32'hA7, BR_SVC_UNI};
        rec_a[3] = '{32'd410,  3, 5, 32'hA3, BR_SVC_UNI};
        rec_a[4] = '{32'd950,  2, 1, 32'hB0, BR_SVC_UNI};
        rec_a[5] = '{32'd950,  2, 2, 32'hB1, BR_SVC_MON};
        rec_a[6] = '{32'd1000, 0, 9, 32'hC0, BR_SVC_UNI};
        rec_a[7] = REC_IDLE;
        rec_b[0] = '{32'd680, 30, 0, 32'h30, BR_SVC_UNI};
        rec_b[1] = '{32'd700,  5, 0, 32'h55, BR_SVC_UNI};
        rec_c[0] = '{32'd4,    1, 3, 32'h44, BR_SVC_ALL};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cycle", cycle_a, 0);
        chk("rst_req",   req_a,   0);
        chk("rst_sent",  sent_a,  0);
        chk("rst_done",  done_a,  0);
        chk("rst_epoch", epoch_c, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;

        wait_cyc(4);
        chk("t1_req_c4",   req_a[4], 0);
        chk("rep_req_c4",  req_c[1], 0);
        wait_cyc(5);
        chk("t1_req_c5",   req_a[4], 1);
        chk("t1_pay_c5",   pay_a[4], 32'h01);
        chk("t1_svc_c5",   svc_a[4], BR_SVC_ALL);
        chk("rep_req_c5",  req_c[1], 1);
        wait_cyc(6);
        chk("t1_sent_c6",  sent_a,   1);
        chk("t1_req_c6",   req_a[4], 0);
        chk("rep_done_c6", done_c,   1);
        chk("rep_sent_c6", sent_c,   1);

        wait_cyc(99);
        chk("rep_epoch_99", epoch_c, 0);
        chk("rep_cyc_99",   cycle_c, 99);
        wait_cyc(100);
        chk("rep_cyc_100",   cycle_c, 0);
        chk("rep_epoch_100", epoch_c, 1);
        chk("rep_done_100",  done_c,  0);
        wait_cyc(105);
        chk("rep_req_105", req_c[1], 1);
        chk("rep_pay_105", pay_c[1], 32'h44);
        chk("rep_cyc_105", cycle_c,  5);
        wait_cyc(106);
        chk("rep_sent_106", sent_c, 2);

        wait_cyc(410);
        chk("t2_req3_410", req_a[3], 0);
        chk("t2_req7_410", req_a[7], 0);
        wait_cyc(411);
        chk("t2_req3_411", req_a[3], 1);
        chk("t2_req7_411", req_a[7], 1);
        chk("t2_pay3_411", pay_a[3], 32'hA3);
        chk("t2_pay7_411", pay_a[7], 32'hA7);
        chk("t2_tgt7_411", tgt_a[7], 5);
        chk("t2_req4_411", req_a[4], 0);
        wait_cyc(412);
        chk("t2_sent_412", sent_a, 3);
        wait_cyc(420);
        chk("t2_req4_420", req_a[4], 0);
        wait_cyc(421);
        chk("t2_req4_421", req_a[4], 1);
        chk("t2_pay4_421", pay_a[4], 32'hA4);
        wait_cyc(422);
        chk("t2_sent_422", sent_a, 4);

        wait_cyc(680);
        chk("drop_680",     drop_b,  0);
        wait_cyc(681);
        chk("drop_681",     drop_b,  1);
        chk("drop_req_681", req_b,   0);
        chk("drop_done",    done_b,  0);
        wait_cyc(701);
        chk("b_req5_701",   req_b[5], 1);
        chk("b_pay5_701",   pay_b[5], 32'h55);
        wait_cyc(702);
        chk("b_done_702",   done_b, 1);
        chk("b_sent_702",   sent_b, 1);
        wait_cyc(710);
        en_b = 1'b0;
        wait_cyc(715);
        chk("b_hold_715",   cycle_b, 710);

        wait_cyc(900);
        ack_a[2] = 1'b0;
        wait_cyc(950);
        chk("t3_req_950", req_a[2], 0);
        wait_cyc(951);
        chk("t3_req_951", req_a[2], 1);
        chk("t3_pay_951", pay_a[2], 32'hB0);
        chk("t3_tgt_951", tgt_a[2], 1);
        wait_cyc(952);
        chk("t3_req_952", req_a[2], 1);
        chk("t3_pay_952", pay_a[2], 32'hB0);
        wait_cyc(953);
        chk("t3_req_953", req_a[2], 1);
        chk("t3_pay_953", pay_a[2], 32'hB0);
        ack_a[2] = 1'b1;
        wait_cyc(954);
        chk("t3_req_954",  req_a[2], 1);
        chk("t3_pay_954",  pay_a[2], 32'hB1);
        chk("t3_tgt_954",  tgt_a[2], 2);
        chk("t3_sent_954", sent_a,   5);
        wait_cyc(955);
        chk("t3_req_955",  req_a[2], 0);
        chk("t3_sent_955", sent_a,   6);

        wait_cyc(1001);
        chk("t6_req0_1001", req_a[0], 1);
        chk("t6_pay0_1001", pay_a[0], 32'hC0);
        rst_a = 1'b1;
        @(negedge clk);
        chk("t6_req",   req_a,    0);
        chk("t6_cycle", cycle_a,  0);
        chk("t6_sent",  sent_a,   0);
        chk("t6_drop",  drop_a,   0);
        chk("t6_epoch", epoch_a,  0);
        chk("t6_pay0",  pay_a[0], 0);
        chk("t6_tgt0",  tgt_a[0], 0);
        chk("t6_done",  done_a,   0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
